// File: rtl/rr_arbiter8.sv
// rr_arbiter8: registered round-robin arbiter for 8 requesters with optional hold-time preemption
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);
  localparam int CW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        r_state;
  logic [2:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic [7:0]    w_rot;
  logic [2:0]    w_off;
  logic [2:0]    w_win;
  logic          w_rel;
  logic          w_pre;
  logic          w_arb;
  // Rotating by ptr makes the last winner the lowest-priority candidate.
  always_comb begin
    w_rot = 8'({req, req} >> r_ptr);
    w_off = 3'd0;
    for (int i = 7; i >= 0; i--) if (w_rot[i]) w_off = 3'(i);
    w_win = r_ptr + w_off;
    w_rel = (r_state == GRANT) && !req[gnt_idx];
    w_pre = (r_state == GRANT) && !w_rel && (HOLD_MAX != 0) && (r_cnt == CW'(HOLD_MAX));
    w_arb = (|req) && ((r_state == IDLE) || w_rel || w_pre);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      gnt       <= 8'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      r_ptr     <= 3'd0;
      r_cnt     <= '0;
    end else begin
      timeout <= w_pre;
      if (w_arb) begin
        r_state   <= GRANT;
        gnt_idx   <= w_win;
        gnt       <= 8'd1 << w_win;
        gnt_valid <= 1'b1;
        r_ptr     <= w_win + 3'd1;
        r_cnt     <= CW'(1);
      end else if (w_rel) begin
        r_state   <= IDLE;
        gnt       <= 8'd0;
        gnt_valid <= 1'b0;
      end else if (r_state == GRANT && r_cnt != '1) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed self-checking bench for rr_arbiter8 (HOLD_MAX=4)
module tb_rr_arbiter8;
  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  int checks = 0;
  int failures = 0;

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {gnt, gnt_idx, gnt_valid, timeout};
  endfunction

  function automatic logic [12:0] ex(input logic [2:0] i, input logic v, input logic t);
    return {(v ? (8'd1 << i) : 8'd0), i, v, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 8'h00;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== 13'd0) begin failures++; $display("FAIL reset_init got=%h exp=%h", obs(), 13'd0); end
    req = 8'h10;
    #3 reset = 1'b0;
    step();
    checks++;
    if (obs() !== ex(3'd4, 1'b1, 1'b0)) begin failures++; $display("FAIL reset_first got=%h exp=%h", obs(), ex(3'd4, 1'b1, 1'b0)); end
    step();
    checks++;
    if (obs() !== ex(3'd4, 1'b1, 1'b0)) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs(), ex(3'd4, 1'b1, 1'b0)); end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== 13'd0) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs(), 13'd0); end
    #2 reset = 1'b0;
    step();
    checks++;
    if (obs() !== ex(3'd4, 1'b1, 1'b0)) begin failures++; $display("FAIL reset_restart got=%h exp=%h", obs(), ex(3'd4, 1'b1, 1'b0)); end
  endtask

  task automatic test_single();
    req = 8'h00;
    step();
    checks++;
    if (obs() !== {8'h00, 3'd4, 1'b0, 1'b0}) begin failures++; $display("FAIL single_idle got=%h exp=%h", obs(), {8'h00, 3'd4, 1'b0, 1'b0}); end
    req = 8'h08;
    step();
    checks++;
    if (obs() !== ex(3'd3, 1'b1, 1'b0)) begin failures++; $display("FAIL single_grant got=%h exp=%h", obs(), ex(3'd3, 1'b1, 1'b0)); end
    req = 8'h00;
    step();
    checks++;
    if (obs() !== {8'h00, 3'd3, 1'b0, 1'b0}) begin failures++; $display("FAIL single_drop got=%h exp=%h", obs(), {8'h00, 3'd3, 1'b0, 1'b0}); end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (obs() !== ex(3'(k % 8), 1'b1, 1'b0)) begin failures++; $display("FAIL rot_grant%0d got=%h exp=%h", k, obs(), ex(3'(k % 8), 1'b1, 1'b0)); end
      step();
      checks++;
      if (obs() !== ex(3'(k % 8), 1'b1, 1'b0)) begin failures++; $display("FAIL rot_hold%0d got=%h exp=%h", k, obs(), ex(3'(k % 8), 1'b1, 1'b0)); end
      req = ~(8'd1 << (k % 8));
      step();
      req = 8'hFF;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'h40;
    step();
    checks++;
    if (obs() !== ex(3'd6, 1'b1, 1'b0)) begin failures++; $display("FAIL wrap_pre got=%h exp=%h", obs(), ex(3'd6, 1'b1, 1'b0)); end
    req = 8'h81;
    step();
    checks++;
    if (obs() !== ex(3'd7, 1'b1, 1'b0)) begin failures++; $display("FAIL wrap_7 got=%h exp=%h", obs(), ex(3'd7, 1'b1, 1'b0)); end
    req = 8'h01;
    step();
    checks++;
    if (obs() !== ex(3'd0, 1'b1, 1'b0)) begin failures++; $display("FAIL wrap_0 got=%h exp=%h", obs(), ex(3'd0, 1'b1, 1'b0)); end
    req = 8'h00;
    step();
    checks++;
    if (obs() !== {8'h00, 3'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL wrap_idle got=%h exp=%h", obs(), {8'h00, 3'd0, 1'b0, 1'b0}); end
  endtask

  task automatic test_preempt();
    logic [2:0] e_idx;
    do_reset();
    req = 8'h05;
    step();
    for (int r = 0; r < 3; r++) begin
      e_idx = (r % 2 == 0) ? 3'd0 : 3'd2;
      for (int c = 1; c <= 4; c++) begin
        checks++;
        if (obs() !== ex(e_idx, 1'b1, (c == 1 && r > 0))) begin
          failures++;
          $display("FAIL preempt_r%0d_c%0d got=%h exp=%h", r, c, obs(), ex(e_idx, 1'b1, (c == 1 && r > 0)));
        end
        step();
      end
    end
  endtask

  task automatic test_sole_holder();
    do_reset();
    req = 8'h20;
    step();
    for (int j = 0; j < 13; j++) begin
      checks++;
      if (obs() !== ex(3'd5, 1'b1, (j > 0 && j % 4 == 0))) begin
        failures++;
        $display("FAIL sole_c%0d got=%h exp=%h", j, obs(), ex(3'd5, 1'b1, (j > 0 && j % 4 == 0)));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_preempt();
    test_sole_holder();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
